// File: rtl/prog_delay_line.sv
// Run-time programmable delay line with valid tagging, stall and flush.
// One MAX_DEPTH-stage chain; the output taps stage[cur_delay-1].
module prog_delay_line #(
    parameter  int WIDTH         = 8,
    parameter  int MAX_DEPTH     = 90,
    parameter  int DEFAULT_DELAY = 30,
    localparam int DW            = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    input  logic             cfg_load,
    input  logic [DW-1:0]    cfg_delay,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [DW-1:0]    cur_delay,
    output logic             cfg_err
);

    logic [WIDTH-1:0]     data_q [MAX_DEPTH];
    logic [WIDTH-1:0]     data_d [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] valid_q;
    logic [MAX_DEPTH-1:0] valid_d;
    logic [DW-1:0]        cur_delay_q;
    logic [DW-1:0]        cur_delay_d;
    logic                 cfg_err_q;
    logic                 cfg_err_d;
    logic                 cfg_ok;
    logic [DW-1:0]        tap_idx;

    assign cfg_ok = (cfg_delay != '0) && (cfg_delay <= DW'(MAX_DEPTH));

    // Chain next state: flush clears tags only and wins over advance.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (adv) begin
            valid_d   = {valid_q[MAX_DEPTH-2:0], in_valid};
            data_d[0] = in_data;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    // Delay register: accept legal requests, flag illegal ones for one cycle.
    always_comb begin
        cur_delay_d = cur_delay_q;
        cfg_err_d   = 1'b0;
        if (cfg_load) begin
            if (cfg_ok) begin
                cur_delay_d = cfg_delay;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q      <= '{default: '0};
            valid_q     <= '0;
            cur_delay_q <= DW'(DEFAULT_DELAY);
            cfg_err_q   <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            cur_delay_q <= cur_delay_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Tap is purely combinational from registered state, so the
    // shortest path from in_data is still one register deep.
    assign tap_idx   = cur_delay_q - DW'(1);
    assign out_data  = data_q[tap_idx];
    assign out_valid = valid_q[tap_idx];
    assign cur_delay = cur_delay_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed testbench for prog_delay_line.
// Sample history model plus an in-order scoreboard for the stall stream.
module tb_prog_delay_line;

    localparam int W    = 8;
    localparam int MAXD = 90;
    localparam int DEFD = 30;
    localparam int DW   = $clog2(MAXD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          adv;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          flush;
    logic          cfg_load;
    logic [DW-1:0] cfg_delay;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [DW-1:0] cur_delay;
    logic          cfg_err;

    int checks   = 0;
    int failures = 0;

    // Accepted samples, newest first: {valid, data}.
    logic [W:0]    hist [$];
    logic [W-1:0]  sb_q [$];
    int            exp_delay;
    logic          exp_err;

    prog_delay_line #(
        .WIDTH(W), .MAX_DEPTH(MAXD), .DEFAULT_DELAY(DEFD)
    ) dut (
        .clk(clk), .rst(rst), .adv(adv),
        .in_valid(in_valid), .in_data(in_data),
        .flush(flush), .cfg_load(cfg_load), .cfg_delay(cfg_delay),
        .out_data(out_data), .out_valid(out_valid),
        .cur_delay(cur_delay), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        int         idx;
        logic       ev;
        logic [W-1:0] ed;
        idx = exp_delay - 1;
        ev  = 1'b0;
        ed  = '0;
        if (idx < hist.size()) begin
            ev = hist[idx][W];
            ed = hist[idx][W-1:0];
        end
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".out_data"},  32'(out_data),  32'(ed));
        chk({tag, ".cur_delay"}, 32'(cur_delay), 32'(exp_delay));
        chk({tag, ".cfg_err"},   32'(cfg_err),   32'(exp_err));
    endtask

    // One clock with the given inputs; model updated, then outputs checked.
    task automatic step(input string tag, input logic a, input logic v,
                        input logic [W-1:0] d, input logic f,
                        input logic cl, input logic [DW-1:0] cd);
        adv = a; in_valid = v; in_data = d;
        flush = f; cfg_load = cl; cfg_delay = cd;
        @(posedge clk);
        if (f) begin
            foreach (hist[i]) hist[i][W] = 1'b0;
        end else if (a) begin
            hist.push_front({v, d});
            if (hist.size() > MAXD) hist.delete(MAXD);
        end
        exp_err = 1'b0;
        if (cl) begin
            if (cd >= 1 && cd <= MAXD) exp_delay = int'(cd);
            else exp_err = 1'b1;
        end
        #1;
        chk_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // Asynchronous reset asserted mid-cycle; checked before any clock edge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        adv = 1'b1; in_valid = 1'b1; flush = 1'b0; cfg_load = 1'b0;
        hist.delete();
        exp_delay = DEFD;
        exp_err   = 1'b0;
        #1;
        chk_all({tag, ".async"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle({tag, ".post"});
    endtask

    initial begin
        int n;
        int first_clk;
        logic [W-1:0] exp_d;

        rst = 1'b1; adv = 1'b0; in_valid = 1'b0; in_data = '0;
        flush = 1'b0; cfg_load = 1'b0; cfg_delay = '0;
        exp_delay = DEFD; exp_err = 1'b0;
        @(posedge clk);
        #1;
        chk_all("reset");
        rst = 1'b0;
        idle("reset_idle");

        // Default latency: sample 1 surfaces after the 30th advance edge.
        for (int k = 1; k <= 40; k++) begin
            step("lat", 1'b1, 1'b1, W'(k), 1'b0, 1'b0, '0);
            if (k == DEFD) begin
                chk("lat_first_valid", 32'(out_valid), 32'd1);
                chk("lat_first_data",  32'(out_data),  32'h01);
            end
        end

        // Mid-stream async reset then illegal configurations.
        do_reset("rst_mid");
        step("cfg0", 1'b0, 1'b0, '0, 1'b0, 1'b1, DW'(0));
        chk("cfg0_err", 32'(cfg_err), 32'd1);
        idle("cfg0_clr");
        step("cfg91", 1'b0, 1'b0, '0, 1'b0, 1'b1, DW'(91));
        chk("cfg91_err", 32'(cfg_err), 32'd1);
        chk("cfg91_delay", 32'(cur_delay), 32'd30);
        idle("cfg91_clr");

        // Stall: adv low for 5 clocks after edge 10.
        n = 0;
        first_clk = -1;
        sb_q.delete();
        for (int c = 1; c <= 60; c++) begin
            if (c >= 11 && c <= 15) begin
                step("stall", 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, '0);
            end else begin
                n++;
                sb_q.push_back(W'(n));
                step("stall", 1'b1, 1'b1, W'(n), 1'b0, 1'b0, '0);
                if (out_valid) begin
                    if (first_clk < 0) first_clk = c;
                    exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
                    chk("stall_sb", 32'(out_data), 32'(exp_d));
                end
            end
        end
        chk("stall_first_clk", 32'(first_clk), 32'd35);
        chk("stall_sb_left", 32'(sb_q.size()), 32'd29);

        // Reconfigure to 1 then to 90 with the stream running.
        do_reset("rst_cfg");
        for (int k = 1; k <= 20; k++)
            step("pre", 1'b1, 1'b1, W'(k), 1'b0, 1'b0, '0);
        step("d1", 1'b1, 1'b1, 8'h21, 1'b0, 1'b1, DW'(1));
        chk("d1_data", 32'(out_data), 32'h21);
        step("d1b", 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, '0);
        chk("d1b_data", 32'(out_data), 32'h22);
        step("d90", 1'b1, 1'b1, 8'h23, 1'b0, 1'b1, DW'(90));
        for (int k = 0; k < 80; k++)
            step("d90_run", 1'b1, 1'b1, W'(8'h24 + k), 1'b0, 1'b0, '0);
        chk("d90_full", 32'(out_valid), 32'd1);

        // Flush priority at steady state with the default delay.
        do_reset("rst_fl");
        for (int k = 1; k <= 40; k++)
            step("fl_pre", 1'b1, 1'b1, W'(k), 1'b0, 1'b0, '0);
        step("flush", 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, '0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        for (int k = 1; k <= 40; k++) begin
            step("fl_post", 1'b1, 1'b1, W'(8'h40 + k), 1'b0, 1'b0, '0);
            chk("no_aa", 32'(out_valid && out_data == 8'hAA), 32'd0);
        end

        // Simultaneous cfg/flush/adv, then a tap change while stalled.
        step("simul", 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, DW'(5));
        for (int k = 1; k <= 8; k++)
            step("simul_run", 1'b1, k[0], W'(8'h60 + k), 1'b0, 1'b0, '0);
        step("stall_tap", 1'b0, 1'b1, 8'h77, 1'b0, 1'b1, DW'(3));
        idle("stall_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
